// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: M-extension op codes, ALU op codes,
// FSM state type and the default datapath width.
`ifndef ALU_CONTROL_WIDTH
`define ALU_CONTROL_WIDTH 4
`endif

package ex_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ALU_CTL_W    = `ALU_CONTROL_WIDTH;

  // funct3 encodings of the RV32M/RV64M ops
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [ALU_CTL_W-1:0] ALU_AND   = ALU_CTL_W'(0);
  localparam logic [ALU_CTL_W-1:0] ALU_OR    = ALU_CTL_W'(1);
  localparam logic [ALU_CTL_W-1:0] ALU_ADD   = ALU_CTL_W'(2);
  localparam logic [ALU_CTL_W-1:0] ALU_XOR   = ALU_CTL_W'(3);
  localparam logic [ALU_CTL_W-1:0] ALU_SLL   = ALU_CTL_W'(4);
  localparam logic [ALU_CTL_W-1:0] ALU_SRL   = ALU_CTL_W'(5);
  localparam logic [ALU_CTL_W-1:0] ALU_SUB   = ALU_CTL_W'(6);
  localparam logic [ALU_CTL_W-1:0] ALU_SLT   = ALU_CTL_W'(7);
  localparam logic [ALU_CTL_W-1:0] ALU_SLTU  = ALU_CTL_W'(8);
  localparam logic [ALU_CTL_W-1:0] ALU_SRA   = ALU_CTL_W'(9);
  localparam logic [ALU_CTL_W-1:0] ALU_LUI   = ALU_CTL_W'(10);
  localparam logic [ALU_CTL_W-1:0] ALU_AUIPC = ALU_CTL_W'(11);
  localparam logic [ALU_CTL_W-1:0] ALU_JAL   = ALU_CTL_W'(12);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ex_state_e;

endpackage

// File: rtl/alu.sv
// Single-cycle integer ALU shared with the original EX stage.
// Operand 2 selection is done by the caller; pc feeds the auipc/jal link paths.
module alu import ex_pkg::*; #(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int ADDR_W = 32,
  parameter int CTL_W  = `ALU_CONTROL_WIDTH
) (
  input  logic [CTL_W-1:0]  ALU_ctl,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic [ADDR_W-1:0] pc,
  output logic [XLEN-1:0]   result,
  output logic              zero
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] shamt;
  logic [XLEN-1:0] pc_x;

  assign shamt = b[SH_W-1:0];
  assign pc_x  = XLEN'(pc);

  always_comb begin
    result = '0;
    unique case (ALU_ctl)
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_ADD:   result = a + b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SUB:   result = a - b;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_LUI:   result = b;
      ALU_AUIPC: result = pc_x + b;
      ALU_JAL:   result = pc_x + XLEN'(4);
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider working on operand magnitudes,
// one step per cycle for XLEN cycles; the sign fix-up folds into the final step.
module muldiv_iter import ex_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN + 1);

  logic [CNT_W-1:0] count_q;
  logic [2:0]       op_q;
  logic [XLEN-1:0]  hi_q, lo_q, b_q;
  logic             neg_q, rem_neg_q, div0_q;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    sum, shifted;
  logic [XLEN-1:0]  diff, hi_n, lo_n;
  logic             ge;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]  quo_fix, rem_fix;

  assign a_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  assign b_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  assign a_neg    = a_signed && a[XLEN-1];
  assign b_neg    = b_signed && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

  // hi holds the partial product / running remainder, lo the multiplier / quotient
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted[XLEN-1:0] - b_q;
    ge      = (shifted >= {1'b0, b_q});
    if (op_q[2]) begin
      hi_n = ge ? diff : shifted[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ge};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  // Divide-by-zero leaves the dividend as remainder naturally; only the quotient needs forcing
  always_comb begin
    prod     = {hi_n, lo_n};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = div0_q ? '1 : (neg_q ? -lo_n : lo_n);
    rem_fix  = rem_neg_q ? -hi_n : hi_n;
    result   = rem_fix;
    unique case (op_q)
      MD_MUL:                        result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               result = quo_fix;
      default:                       result = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      op_q      <= MD_MUL;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
    end else if (start) begin
      count_q   <= CNT_W'(XLEN);
      op_q      <= op;
      hi_q      <= '0;
      lo_q      <= a_mag;
      b_q       <= b_mag;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      div0_q    <= (b == '0);
    end else if (count_q != '0) begin
      count_q   <= count_q - CNT_W'(1);
      hi_q      <= hi_n;
      lo_q      <= lo_n;
    end
  end

  assign busy = (count_q != '0);
  assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle ALU plus iterative M-extension unit behind one
// valid/ready front end and one registered result port.
//
//   state | meaning
//   IDLE  | no result held, ready for a new op
//   RUN   | multiply/divide iterating (incl. final fix-up step)
//   DONE  | result valid, held until out_ready
module ex_muldiv import ex_pkg::*; #(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int ADDR_W = 32,
  parameter int CTL_W  = `ALU_CONTROL_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   read_data_1,
  input  logic [XLEN-1:0]   read_data_2,
  input  logic [XLEN-1:0]   imm,
  input  logic [ADDR_W-1:0] pc,
  input  logic [CTL_W-1:0]  ALU_ctl,
  input  logic              ALUSrc,
  input  logic              md_en,
  input  logic [2:0]        md_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   ALU_result,
  output logic              zero,
  output logic              busy
);

  ex_state_e       state_q, state_d;
  logic            accept, md_start, md_done, alu_zero;
  logic [XLEN-1:0] alu_b, alu_res, md_res;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && md_en;
  assign alu_b    = ALUSrc ? imm : read_data_2;

  alu #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W),
    .CTL_W  (CTL_W)
  ) u_alu (
    .ALU_ctl (ALU_ctl),
    .a       (read_data_1),
    .b       (alu_b),
    .pc      (pc),
    .result  (alu_res),
    .zero    (alu_zero)
  );

  muldiv_iter #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .op     (md_op),
    .a      (read_data_1),
    .b      (read_data_2),
    .busy   (busy),
    .done   (md_done),
    .result (md_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = md_en ? RUN : DONE;
      RUN:  if (md_done) state_d = DONE;
      DONE: begin
        if (accept)         state_d = md_en ? RUN : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready is low throughout RUN, so an ALU accept and md_done never coincide
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (accept && !md_en) begin
      result_q <= alu_res;
      zero_q   <= alu_zero;
    end else if (md_done) begin
      result_q <= md_res;
      zero_q   <= (md_res == '0);
    end
  end

  assign out_valid  = (state_q == DONE);
  assign ALU_result = result_q;
  assign zero       = zero_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized bench for ex_muldiv (XLEN=32) against a plain-arithmetic reference.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] read_data_1, read_data_2, imm, pc;
  logic [3:0]  ALU_ctl;
  logic        ALUSrc, md_en;
  logic [2:0]  md_op;
  logic        out_valid, out_ready;
  logic [31:0] ALU_result;
  logic        zero, busy;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .read_data_1 (read_data_1),
    .read_data_2 (read_data_2),
    .imm         (imm),
    .pc          (pc),
    .ALU_ctl     (ALU_ctl),
    .ALUSrc      (ALUSrc),
    .md_en       (md_en),
    .md_op       (md_op),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ALU_result  (ALU_result),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] pcv);
    case (c)
      ex_pkg::ALU_AND:   return a & b;
      ex_pkg::ALU_OR:    return a | b;
      ex_pkg::ALU_ADD:   return a + b;
      ex_pkg::ALU_XOR:   return a ^ b;
      ex_pkg::ALU_SLL:   return a << b[4:0];
      ex_pkg::ALU_SRL:   return a >> b[4:0];
      ex_pkg::ALU_SUB:   return a - b;
      ex_pkg::ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ex_pkg::ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ex_pkg::ALU_SRA:   return $unsigned($signed(a) >>> b[4:0]);
      ex_pkg::ALU_LUI:   return b;
      ex_pkg::ALU_AUIPC: return pcv + b;
      ex_pkg::ALU_JAL:   return pcv + 32'd4;
      default:           return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 50));
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] alu_ops [13] = '{ex_pkg::ALU_AND, ex_pkg::ALU_OR, ex_pkg::ALU_ADD, ex_pkg::ALU_XOR,
                               ex_pkg::ALU_SLL, ex_pkg::ALU_SRL, ex_pkg::ALU_SUB, ex_pkg::ALU_SLT,
                               ex_pkg::ALU_SLTU, ex_pkg::ALU_SRA, ex_pkg::ALU_LUI, ex_pkg::ALU_AUIPC,
                               ex_pkg::ALU_JAL};

  task automatic drive(input logic m, input logic [2:0] mop, input logic [3:0] ctl, input logic src,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic [31:0] pcv);
    in_valid = 1'b1; md_en = m; md_op = mop; ALU_ctl = ctl; ALUSrc = src;
    read_data_1 = a; read_data_2 = b; imm = im; pc = pcv;
  endtask

  task automatic scramble();
    in_valid = 1'b0; md_en = 1'($urandom); md_op = 3'($urandom); ALU_ctl = 4'($urandom);
    ALUSrc = 1'($urandom); read_data_1 = $urandom; read_data_2 = $urandom; imm = $urandom; pc = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Called one step after a clock edge with the DUT idle and out_ready high.
  task automatic run_op(input string tag, input logic m, input logic [2:0] mop, input logic [3:0] ctl,
                        input logic src, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] pcv);
    logic [31:0] exp;
    int          lat;
    exp = m ? ref_md(mop, a, b) : ref_alu(ctl, a, src ? im : b, pcv);
    drive(m, mop, ctl, src, a, b, im, pcv);
    @(posedge clk); #1;
    scramble();
    check({tag, ".busy"}, busy, m);
    wait_valid(lat);
    check({tag, ".lat"}, lat, m ? 33 : 1);
    check({tag, ".res"}, ALU_result, exp);
    check({tag, ".zero"}, zero, exp == 32'd0);
    if (m) check({tag, ".busy_end"}, busy, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_b2b [8];
    logic [31:0] a, b, im, pcv, exp;
    logic [3:0]  ctl;
    logic        src;
    logic [2:0]  op;
    int          lat, stale;

    rst = 1'b1; out_ready = 1'b1;
    scramble();
    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.result", ALU_result, 0);
    check("rst.zero", zero, 1);
    check("rst.in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add", 1'b0, 3'd0, ex_pkg::ALU_ADD, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0);
    run_op("mulh",   1'b1, ex_pkg::MD_MULH,  4'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
    run_op("mulhu",  1'b1, ex_pkg::MD_MULHU, 4'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    run_op("mul",    1'b1, ex_pkg::MD_MUL,   4'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
    run_op("div",    1'b1, ex_pkg::MD_DIV,   4'd0, 1'b0, -32'sd7, 32'd2, 32'd0, 32'd0);
    run_op("rem",    1'b1, ex_pkg::MD_REM,   4'd0, 1'b0, -32'sd7, 32'd2, 32'd0, 32'd0);
    run_op("divu",   1'b1, ex_pkg::MD_DIVU,  4'd0, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0);
    run_op("remu",   1'b1, ex_pkg::MD_REMU,  4'd0, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0);
    run_op("div0",   1'b1, ex_pkg::MD_DIV,   4'd0, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0);
    run_op("rem0",   1'b1, ex_pkg::MD_REM,   4'd0, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0);
    run_op("divovf", 1'b1, ex_pkg::MD_DIV,   4'd0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    run_op("removf", 1'b1, ex_pkg::MD_REM,   4'd0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);

    // back-to-back ALU ops, one per cycle
    for (int i = 0; i < 8; i++) begin
      ctl = alu_ops[$urandom_range(0, 12)];
      src = 1'($urandom); a = pick_operand(); b = pick_operand(); im = $urandom; pcv = $urandom;
      exp_b2b[i] = ref_alu(ctl, a, src ? im : b, pcv);
      drive(1'b0, 3'd0, ctl, src, a, b, im, pcv);
      @(posedge clk); #1;
      check($sformatf("b2b%0d.valid", i), out_valid, 1);
      check($sformatf("b2b%0d.res", i), ALU_result, exp_b2b[i]);
      check($sformatf("b2b%0d.in_ready", i), in_ready, 1);
    end
    scramble();
    @(posedge clk); #1;
    check("b2b.idle", out_valid, 0);

    for (int i = 0; i < 20; i++) begin
      ctl = alu_ops[$urandom_range(0, 12)];
      run_op($sformatf("ralu%0d", i), 1'b0, 3'd0, ctl, 1'($urandom), pick_operand(), pick_operand(),
             pick_operand(), $urandom);
    end

    for (int i = 0; i < 30; i++) begin
      run_op($sformatf("rmd%0d", i), 1'b1, 3'($urandom), 4'd0, 1'($urandom), pick_operand(),
             pick_operand(), $urandom, $urandom);
    end

    // backpressure in DONE, then a same-cycle handoff to the next M op
    out_ready = 1'b0;
    a = $urandom; b = 32'($urandom_range(1, 1000));
    exp = ref_md(ex_pkg::MD_DIVU, a, b);
    drive(1'b1, ex_pkg::MD_DIVU, 4'd0, 1'b0, a, b, 32'd0, 32'd0);
    @(posedge clk); #1;
    scramble();
    wait_valid(lat);
    check("bp.lat", lat, 33);
    check("bp.res", ALU_result, exp);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp.hold%0d.valid", i), out_valid, 1);
      check($sformatf("bp.hold%0d.res", i), ALU_result, exp);
      check($sformatf("bp.hold%0d.in_ready", i), in_ready, 0);
    end
    drive(1'b1, ex_pkg::MD_REMU, 4'd0, 1'b0, a, b, 32'd0, 32'd0);
    #1;
    check("bp.pending.in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp.release.in_ready", in_ready, 1);
    @(posedge clk); #1;
    scramble();
    check("bp.next.busy", busy, 1);
    check("bp.next.valid", out_valid, 0);
    wait_valid(lat);
    check("bp.next.lat", lat, 33);
    check("bp.next.res", ALU_result, ref_md(ex_pkg::MD_REMU, a, b));
    @(posedge clk); #1;

    // reset in the middle of a DIVU discards it
    drive(1'b1, ex_pkg::MD_DIVU, 4'd0, 1'b0, 32'd1000, 32'd3, 32'd0, 32'd0);
    @(posedge clk); #1;
    scramble();
    repeat (9) begin @(posedge clk); #1; end
    check("abort.busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.out_valid", out_valid, 0);
    check("abort.busy", busy, 0);
    check("abort.result", ALU_result, 0);
    check("abort.zero", zero, 1);
    check("abort.in_ready", in_ready, 1);
    stale = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) stale++;
    end
    check("abort.stale", stale, 0);

    run_op("post_rst", 1'b1, ex_pkg::MD_MULHSU, 4'd0, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised execute stage that replaces the single-cycle EX block. Single-cycle ALU operations (via the existing ALU) and iterative RV32M/RV64M multiply/divide operations share one valid/ready front end and one registered result port. The block sits between ID and MEM/WB and stalls the pipeline through `in_ready` while a multi-cycle operation runs.

## Interface
Parameters:
- `XLEN`, 32: operand/result width (32 or 64).
- `ADDR_W`, 32: PC width.
- `CTL_W`, `` `ALU_CONTROL_WIDTH ``: ALU control width.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  ID presents an operation.
- `in_ready`  out  1  block accepts it this cycle.
- `read_data_1`  in  XLEN  rs1 operand.
- `read_data_2`  in  XLEN  rs2 operand.
- `imm`  in  XLEN  immediate.
- `pc`  in  ADDR_W  instruction PC (for jal/auipc paths in ALU).
- `ALU_ctl`  in  CTL_W  ALU operation.
- `ALUSrc`  in  1  0: operand 2 = rs2, 1: operand 2 = imm.
- `md_en`  in  1  1: M-extension op, `ALU_ctl`/`ALUSrc` ignored.
- `md_op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `out_valid`  out  1  `ALU_result`/`zero` valid.
- `out_ready`  in  1  downstream consumes the result.
- `ALU_result`  out  XLEN  registered result.
- `zero`  out  1  registered `ALU_result == 0`.
- `busy`  out  1  multiply/divide iteration in progress.

## Operation
- States: IDLE, RUN, DONE.
- `in_ready` = (IDLE) or (DONE and `out_ready`).
- Accept (`in_valid && in_ready`) with `md_en=0`: ALU result and `zero` registered; state -> DONE.
- Accept with `md_en=1`: operands latched, sign-corrected to magnitudes per op. Counter is loaded with XLEN. State -> RUN.
- RUN: one shift-add (MUL*) or restoring-subtract (DIV*/REM*) step per cycle; counter decrements. At count 0 the sign fix-up is applied and the result is registered; state -> DONE.
- MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits of the 2·XLEN product, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- DONE: `out_valid=1`, outputs held stable until `out_ready`.
  - `out_ready` with no new accept: -> IDLE.
  - `out_ready` with a back-to-back accept: -> DONE (ALU op) or RUN (md op).
- Divide by zero: quotient = all ones, remainder = dividend.
- Signed overflow (dividend = −2^(XLEN−1), divisor = −1): quotient = dividend, remainder = 0.
- Both special cases keep the full latency. No exceptions are raised.
- `rst`: state IDLE, `out_valid=0`, `busy=0`, `ALU_result=0`, `zero=1`, counter 0. A reset during RUN aborts the operation and discards its result.

## Timing
- The operation is accepted at edge 0.
- ALU op: `out_valid` is high after edge 1 (latency 1).
- M op: `busy` is high for XLEN cycles; `out_valid` is high after edge XLEN+1.
- Throughput: 1 ALU op/cycle while `out_ready=1`; 1 M op per XLEN+1 cycles.
- `in_ready` is low for the whole of RUN, and during DONE while `out_ready=0`.
- Inputs are sampled only on the accept edge. Operand changes during RUN have no effect.

## Structure
- Package `ex_pkg` holds:
  - `md_op` encodings as localparams;
  - the state enum {IDLE, RUN, DONE};
  - the `XLEN` default.
- The existing ALU is reused unchanged for the single-cycle path, with the ALUSrc mux in the top level.
- One new sub-module, `muldiv_iter`, holds:
  - the operand/accumulator registers, counter and step datapath;
  - start/done pins.
- The top level owns the FSM, the valid/ready logic and the output registers.

## Test plan
- ADD via ALU, rs1=5, rs2=7, `out_ready=1` -> `ALU_result=12`, `zero=0`, `out_valid` one cycle after accept; back-to-back ops complete one per cycle.
- MULH, rs1=0x80000000, rs2=0x80000000 -> 0x40000000 at cycle 33. MULHU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFE. MUL, 0x80000000 × 0x80000000 -> 0, `zero=1`.
- DIV −7/2 -> 0xFFFFFFFD (−3); REM −7/2 -> 0xFFFFFFFF (−1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/−1 -> 0x80000000; REM 0x80000000/−1 -> 0.
- Hold `out_ready=0` for 5 cycles in DONE -> outputs stable, `in_ready=0`. Raise `out_ready` with `in_valid` and an M op pending -> the next op is accepted the same cycle and `busy` rises.
- Assert `rst` at cycle 10 of a DIVU -> next cycle state IDLE, `out_valid=0`, `busy=0`, `ALU_result=0`, `zero=1`; no stale result appears.
